fp_mac_result_buffer: RTL and testbench

Result buffer and issue-credit tracker placed directly downstream of the FP MAC wrapper. The MAC has a fixed-latency pipeline, never stalls and ignores its acknowledge. This block therefore captures every MAC result into a small FIFO and presents it to the APU result interconnect with a valid/ack handshake. It also grants issue credits upstream so the number of in-flight plus buffered operations never exceeds FIFO depth.

---
 rtl/apu_cluster_package.sv | 19 +
 rtl/apu_fifo_ctrl.sv | 78 +++++++
 rtl/fp_mac_result_buffer.sv | 95 +++++++++
 tb/tb_fp_mac_result_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_cluster_package.sv
// Shared APU cluster types and constants.
//   FP_WIDTH            result width of the FP units
//   NUSFLAGS_MAC        number of status flags produced by the FP MAC
//   C_MAC_RESBUF_DEPTH  default depth of the MAC result buffer
//   fp_mac_result_t     one buffered MAC result {res, tag, status}
package apu_cluster_package;

  localparam int FP_WIDTH           = 32;
  localparam int NUSFLAGS_MAC       = 5;
  localparam int C_MAC_RESBUF_DEPTH = 4;

  // Field order matches the packed entry used by the result buffer.
  typedef struct packed {
    logic [FP_WIDTH-1:0]     res;
    logic [4:0]              tag;
    logic [NUSFLAGS_MAC-1:0] status;
  } fp_mac_result_t;

endpackage

// File: rtl/apu_fifo_ctrl.sv
// Generic circular FIFO with occupancy counter, reusable by APU units.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   wr_req_i      write request (accepted when not full, or full with a pop)
//   wdata_i       write data
//   rd_ack_i      consumer accepts the head (ignored while empty)
//   valid_o       head valid
//   rdata_o       head data (zero while empty)
//   count_o       occupancy
//   full_o        occupancy == DEPTH
//   wr_drop_o     write request dropped because full and no pop this cycle
module apu_fifo_ctrl #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_req_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       rd_ack_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       wr_drop_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]               rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic                        push, pop, full, empty;

  always_comb begin
    full   = (cnt_q == CW'(DEPTH));
    empty  = (cnt_q == '0);
    pop    = ~empty & rd_ack_i;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push   = wr_req_i & (~full | pop);
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    // Explicit wrap so non-power-of-two depths work.
    if (pop)  rptr_d = (rptr_q == PW'(DEPTH-1)) ? '0 : rptr_q + PW'(1);
    if (push) wptr_d = (wptr_q == PW'(DEPTH-1)) ? '0 : wptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage has no reset; the output mask below hides stale/unwritten entries.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end

  assign valid_o   = ~empty;
  assign rdata_o   = empty ? '0 : mem_q[rptr_q];
  assign count_o   = cnt_q;
  assign full_o    = full;
  assign wr_drop_o = wr_req_i & full & ~pop;

endmodule

// File: rtl/fp_mac_result_buffer.sv
// Result buffer and issue-credit tracker behind the FP MAC.
// The MAC never stalls, so every result is captured in a FIFO and offered
// downstream with Valid_o/Ack_i. Issue credits bound in-flight + buffered ops
// to DEPTH so a well-behaved upstream can never overflow the FIFO.
// Ports:
//   clk_i, rst_i                         clock, async active-high reset
//   Issue_i / IssueReady_o               upstream issue and credit available
//   MacValid_i, MacRes_i, MacTag_i, MacStatus_i   MAC result input
//   Valid_o, Res_o, Tag_o, Status_o, Ack_i        head of buffer, handshake
//   Count_o                              FIFO occupancy
//   Overflow_o                           sticky: result arrived with no room
module fp_mac_result_buffer
  import apu_cluster_package::*;
#(
  parameter int DEPTH      = C_MAC_RESBUF_DEPTH,
  parameter int TAG_WIDTH  = 5,
  parameter int STAT_WIDTH = NUSFLAGS_MAC,
  parameter int FP_WIDTH   = apu_cluster_package::FP_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       Issue_i,
  output logic                       IssueReady_o,
  input  logic                       MacValid_i,
  input  logic [FP_WIDTH-1:0]        MacRes_i,
  input  logic [TAG_WIDTH-1:0]       MacTag_i,
  input  logic [STAT_WIDTH-1:0]      MacStatus_i,
  output logic                       Valid_o,
  output logic [FP_WIDTH-1:0]        Res_o,
  output logic [TAG_WIDTH-1:0]       Tag_o,
  output logic [STAT_WIDTH-1:0]      Status_o,
  input  logic                       Ack_i,
  output logic [$clog2(DEPTH+1)-1:0] Count_o,
  output logic                       Overflow_o
);

  localparam int CW      = $clog2(DEPTH+1);
  localparam int ENTRY_W = FP_WIDTH + TAG_WIDTH + STAT_WIDTH;

  logic [ENTRY_W-1:0] wentry, rentry;
  logic               full, drop, pop;
  logic [CW-1:0]      outstanding_q, outstanding_d;
  logic               overflow_q, overflow_d;
  logic               issue_ready, inc, dec;

  assign wentry = {MacRes_i, MacTag_i, MacStatus_i};

  apu_fifo_ctrl #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_req_i  (MacValid_i),
    .wdata_i   (wentry),
    .rd_ack_i  (Ack_i),
    .valid_o   (Valid_o),
    .rdata_o   (rentry),
    .count_o   (Count_o),
    .full_o    (full),
    .wr_drop_o (drop)
  );

  assign {Res_o, Tag_o, Status_o} = rentry;

  // Credit readiness comes straight from the register: no path from Ack_i/Issue_i.
  assign issue_ready  = (outstanding_q < CW'(DEPTH));
  assign IssueReady_o = issue_ready;
  assign Overflow_o   = overflow_q;

  always_comb begin
    pop           = Valid_o & Ack_i;
    inc           = Issue_i & issue_ready;
    // Saturate at zero: a stray MAC result with no credit must not wrap.
    dec           = pop & (outstanding_q != '0);
    outstanding_d = outstanding_q;
    case ({inc, dec})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      overflow_q    <= overflow_d;
    end
  end

endmodule

// File: tb/tb_fp_mac_result_buffer.sv
module tb_fp_mac_result_buffer;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        Issue_i = 1'b0, IssueReady_o;
  logic        MacValid_i = 1'b0;
  logic [31:0] MacRes_i = '0;
  logic [4:0]  MacTag_i = '0, MacStatus_i = '0;
  logic        Valid_o;
  logic [31:0] Res_o;
  logic [4:0]  Tag_o, Status_o;
  logic        Ack_i = 1'b0;
  logic [2:0]  Count_o;
  logic        Overflow_o;

  fp_mac_result_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i), .Issue_i(Issue_i), .IssueReady_o(IssueReady_o),
    .MacValid_i(MacValid_i), .MacRes_i(MacRes_i), .MacTag_i(MacTag_i),
    .MacStatus_i(MacStatus_i), .Valid_o(Valid_o), .Res_o(Res_o), .Tag_o(Tag_o),
    .Status_o(Status_o), .Ack_i(Ack_i), .Count_o(Count_o), .Overflow_o(Overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: a queue of results, a credit integer, a sticky flag.
  typedef struct { logic [31:0] r; logic [4:0] t; logic [4:0] s; } ent_t;
  ent_t mq[$];
  int   m_out = 0;
  bit   m_ovf = 0;
  int   vectors = 0, miscompares = 0;

  function automatic int exp_cnt();   return mq.size(); endfunction
  function automatic bit exp_rdy();   return m_out < DEPTH; endfunction
  function automatic logic [31:0] exp_res(); return mq.size() ? mq[0].r : 32'h0; endfunction
  function automatic logic [4:0]  exp_tag(); return mq.size() ? mq[0].t : 5'h0; endfunction
  function automatic logic [4:0]  exp_st();  return mq.size() ? mq[0].s : 5'h0; endfunction

  function automatic void model_reset();
    mq.delete(); m_out = 0; m_ovf = 0;
  endfunction

  // Called at a negedge: drives inputs, advances one clock, returns at next negedge.
  task automatic step(input bit iss, input bit mv, input logic [31:0] r,
                      input logic [4:0] t, input logic [4:0] s, input bit ack);
    bit pop, push, ovf, inc, dec;
    ent_t e;
    Issue_i = iss; MacValid_i = mv; MacRes_i = r; MacTag_i = t; MacStatus_i = s; Ack_i = ack;
    pop  = (mq.size() > 0) && ack;
    push = mv && ((mq.size() < DEPTH) || pop);
    ovf  = mv && (mq.size() == DEPTH) && !pop;
    inc  = iss && (m_out < DEPTH);
    dec  = pop && (m_out > 0);
    e.r = r; e.t = t; e.s = s;
    @(posedge clk_i);
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(e);
    m_out = m_out + int'(inc) - int'(dec);
    if (ovf) m_ovf = 1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    vectors++;
    if (Valid_o !== 1'b0 || Count_o !== 3'd0 || Overflow_o !== 1'b0 || IssueReady_o !== 1'b1 ||
        Res_o !== 32'h0 || Tag_o !== 5'h0 || Status_o !== 5'h0) begin
      miscompares++;
      $display("FAIL reset_initial: v=%b c=%0d ovf=%b rdy=%b res=%h tag=%h st=%h, required all zero except rdy=1",
               Valid_o, Count_o, Overflow_o, IssueReady_o, Res_o, Tag_o, Status_o);
    end
    rst_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    for (int i = 0; i < 3; i++) step(1, 1, 32'h1000 + i, 5'(i + 1), 5'(i), 0);
    vectors++;
    if (Count_o !== 3'd3) begin
      miscompares++; $display("FAIL reset_fill: count=%0d required 3", Count_o);
    end
    // Assert reset mid-burst, away from a clock edge.
    Issue_i = 1; MacValid_i = 1; MacTag_i = 5'h7;
    #2 rst_i = 1'b1;
    #1;
    vectors++;
    if (Valid_o !== 1'b0 || Count_o !== 3'd0 || Overflow_o !== 1'b0 || IssueReady_o !== 1'b1 ||
        Res_o !== 32'h0 || Tag_o !== 5'h0 || Status_o !== 5'h0) begin
      miscompares++;
      $display("FAIL reset_async: v=%b c=%0d ovf=%b rdy=%b res=%h tag=%h, required reset values",
               Valid_o, Count_o, Overflow_o, IssueReady_o, Res_o, Tag_o);
    end
    Issue_i = 0; MacValid_i = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (IssueReady_o !== 1'b1 || Count_o !== 3'd0) begin
      miscompares++; $display("FAIL reset_release: rdy=%b cnt=%0d required 1/0", IssueReady_o, Count_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_credit_exhaustion();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (IssueReady_o !== 1'b1) begin
        miscompares++; $display("FAIL credit_ready_%0d: rdy=%b required 1", i, IssueReady_o);
      end
      step(1, 0, 0, 0, 0, 0);
    end
    vectors++;
    if (IssueReady_o !== 1'b0) begin
      miscompares++; $display("FAIL credit_exhausted: rdy=%b required 0", IssueReady_o);
    end
    step(1, 0, 0, 0, 0, 0);   // ignored 5th issue
    for (int i = 0; i < 4; i++) step(0, 1, 32'hA000 + i, 5'(i + 1), 5'(i + 2), 0);
    vectors++;
    if (Count_o !== 3'd4 || Overflow_o !== 1'b0 || IssueReady_o !== 1'b0 || Tag_o !== 5'd1) begin
      miscompares++;
      $display("FAIL credit_full: cnt=%0d ovf=%b rdy=%b tag=%0d required 4/0/0/1",
               Count_o, Overflow_o, IssueReady_o, Tag_o);
    end
  endtask

  task automatic test_push_pop_full();
    step(0, 1, 32'h9999, 5'd9, 5'd3, 1);
    vectors++;
    if (Count_o !== 3'd4 || Overflow_o !== 1'b0 || Tag_o !== 5'd2) begin
      miscompares++;
      $display("FAIL push_pop_full: cnt=%0d ovf=%b head_tag=%0d required 4/0/2", Count_o, Overflow_o, Tag_o);
    end
    // The freed credit (4 -> 3) shows on IssueReady_o right away.
    vectors++;
    if (IssueReady_o !== 1'b1) begin
      miscompares++; $display("FAIL push_pop_credit: rdy=%b required 1", IssueReady_o);
    end
  endtask

  task automatic test_overflow();
    logic [4:0] want [4];
    want[0] = 5'd2; want[1] = 5'd3; want[2] = 5'd4; want[3] = 5'd9;
    step(0, 1, 32'hDEAD, 5'h1F, 5'h1F, 0);
    vectors++;
    if (Overflow_o !== 1'b1 || Count_o !== 3'd4) begin
      miscompares++; $display("FAIL overflow_set: ovf=%b cnt=%0d required 1/4", Overflow_o, Count_o);
    end
    step(0, 0, 0, 0, 0, 0);
    vectors++;
    if (Overflow_o !== 1'b1) begin
      miscompares++; $display("FAIL overflow_sticky: ovf=%b required 1", Overflow_o);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (Valid_o !== 1'b1 || Tag_o !== want[i] || Res_o !== exp_res()) begin
        miscompares++;
        $display("FAIL overflow_drain_%0d: v=%b tag=%0d res=%h required 1/%0d/%h",
                 i, Valid_o, Tag_o, Res_o, want[i], exp_res());
      end
      step(0, 0, 0, 0, 0, 1);
    end
    vectors++;
    if (Valid_o !== 1'b0 || Count_o !== 3'd0 || Overflow_o !== 1'b1) begin
      miscompares++; $display("FAIL overflow_empty: v=%b cnt=%0d ovf=%b required 0/0/1", Valid_o, Count_o, Overflow_o);
    end
  endtask

  task automatic test_throughput();
    logic [31:0] vals [5];
    vals[0] = 32'h3F800000; vals[1] = 32'h40000000; vals[2] = 32'h40400000;
    vals[3] = 32'h40800000; vals[4] = 32'h40A00000;
    step(1, 1, vals[0], 5'd0, 5'd0, 1);
    for (int i = 1; i < 5; i++) begin
      vectors++;
      if (Valid_o !== 1'b1 || Res_o !== vals[i-1] || IssueReady_o !== 1'b1 || Count_o !== 3'd1) begin
        miscompares++;
        $display("FAIL throughput_%0d: v=%b res=%h rdy=%b cnt=%0d required 1/%h/1/1",
                 i, Valid_o, Res_o, IssueReady_o, Count_o, vals[i-1]);
      end
      step(1, 1, vals[i], 5'(i), 5'd0, 1);
    end
    vectors++;
    if (Res_o !== vals[4] || IssueReady_o !== 1'b1) begin
      miscompares++; $display("FAIL throughput_last: res=%h rdy=%b required %h/1", Res_o, IssueReady_o, vals[4]);
    end
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_ordering_wrap();
    logic [4:0] obs[$];
    int guard;
    for (int i = 1; i <= 6; i++) begin
      bit ack;
      ack = (exp_cnt() >= 2);
      if (Valid_o && ack) obs.push_back(Tag_o);
      step(1, 1, 32'(i * 3), 5'(i), 5'(i), ack);
      vectors++;
      if (Count_o > 3'd3 || int'(Count_o) != exp_cnt()) begin
        miscompares++; $display("FAIL order_count_%0d: cnt=%0d required %0d", i, Count_o, exp_cnt());
      end
    end
    guard = 0;
    while (Valid_o && guard < 10) begin
      obs.push_back(Tag_o);
      step(0, 0, 0, 0, 0, 1);
      guard++;
    end
    vectors++;
    if (obs.size() != 6) begin
      miscompares++; $display("FAIL order_size: popped %0d required 6", obs.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (obs[i] !== 5'(i + 1)) begin
          miscompares++; $display("FAIL order_tag_%0d: tag=%0d required %0d", i, obs[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit iss, mv, ack;
      iss = ($urandom_range(0, 99) < 60);
      mv  = ($urandom_range(0, 99) < 45);
      ack = ($urandom_range(0, 99) < 50);
      step(iss, mv, $urandom, 5'($urandom), 5'($urandom), ack);
      vectors++;
      if (Valid_o !== (exp_cnt() > 0) || int'(Count_o) != exp_cnt() || IssueReady_o !== exp_rdy() ||
          Overflow_o !== m_ovf || Res_o !== exp_res() || Tag_o !== exp_tag() || Status_o !== exp_st()) begin
        miscompares++;
        $display("FAIL random_%0d: v=%b cnt=%0d rdy=%b ovf=%b res=%h tag=%h st=%h required %b/%0d/%b/%b/%h/%h/%h",
                 n, Valid_o, Count_o, IssueReady_o, Overflow_o, Res_o, Tag_o, Status_o,
                 exp_cnt() > 0, exp_cnt(), exp_rdy(), m_ovf, exp_res(), exp_tag(), exp_st());
      end
    end
  endtask

  initial begin
    @(negedge clk_i);
    @(negedge clk_i);
    test_reset();
    test_credit_exhaustion();
    test_push_pop_full();
    test_overflow();
    test_throughput();
    test_ordering_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
